// File: rtl/jtag_tap_master.sv
// JTAG TAP master: pops IR/DR words from show-ahead FIFOs, drives tck/tms/tdi
// and returns captured tdo bytes. After reset it walks the TAP to Run-Test/Idle.
module jtag_tap_master #(
    parameter int DATA_INSTRUCTION = 10,
    parameter int DATA_FIFO        = 8,
    parameter int FIFO_DEPTH       = 16,
    parameter int TCK_DIV          = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        op,
    input  logic                        work,
    output logic                        busy,
    output logic                        err_empty,
    input  logic [DATA_INSTRUCTION-1:0] rdata_instruction,
    output logic                        rd_instruction,
    input  logic                        empty_instruction,
    input  logic [DATA_FIFO-1:0]        rdata_data,
    output logic                        rd_data,
    input  logic                        empty_data,
    output logic                        tck,
    output logic                        tms,
    output logic                        tdi,
    input  logic                        tdo,
    output logic [DATA_FIFO-1:0]        rx_data,
    output logic                        rx_valid
);

    localparam int W  = (DATA_INSTRUCTION > DATA_FIFO) ? DATA_INSTRUCTION : DATA_FIFO;
    localparam int DW = $clog2(TCK_DIV);
    localparam int CW = $clog2(W + 6);
    localparam int BW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        ST_TLR, ST_IDLE, ST_IR_HDR, ST_DR_HDR, ST_SHIFT, ST_TAIL
    } state_t;

    state_t               r_state, w_state_n;
    logic [DW-1:0]        r_div, w_div_n;
    logic [CW-1:0]        r_cnt, w_cnt_n, w_nb;
    logic [W-1:0]         r_tx, w_tx_n;
    logic [DATA_FIFO-1:0] r_rx, w_rx_n, r_rxd, w_rxd_n;
    logic [BW-1:0]        r_bytes, w_bytes_n;
    logic                 r_op, w_op_n;
    logic                 r_tck, w_tck_n, r_tms, w_tms_n, r_tdi, w_tdi_n;
    logic                 r_busy, w_busy_n, r_err, w_err_n;
    logic                 r_rd_i, w_rd_i_n, r_rd_d, w_rd_d_n, r_rxv, w_rxv_n;
    logic                 w_edge, w_rise, w_fall, w_dr_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_TLR;
            r_div   <= '0;
            r_cnt   <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_rxd   <= '0;
            r_bytes <= '0;
            r_op    <= 1'b0;
            r_tck   <= 1'b0;
            r_tms   <= 1'b1;
            r_tdi   <= 1'b0;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            r_rd_i  <= 1'b0;
            r_rd_d  <= 1'b0;
            r_rxv   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_div   <= w_div_n;
            r_cnt   <= w_cnt_n;
            r_tx    <= w_tx_n;
            r_rx    <= w_rx_n;
            r_rxd   <= w_rxd_n;
            r_bytes <= w_bytes_n;
            r_op    <= w_op_n;
            r_tck   <= w_tck_n;
            r_tms   <= w_tms_n;
            r_tdi   <= w_tdi_n;
            r_busy  <= w_busy_n;
            r_err   <= w_err_n;
            r_rd_i  <= w_rd_i_n;
            r_rd_d  <= w_rd_d_n;
            r_rxv   <= w_rxv_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_div_n   = r_div;
        w_cnt_n   = r_cnt;
        w_tx_n    = r_tx;
        w_rx_n    = r_rx;
        w_rxd_n   = r_rxd;
        w_bytes_n = r_bytes;
        w_op_n    = r_op;
        w_tck_n   = r_tck;
        w_tms_n   = r_tms;
        w_tdi_n   = r_tdi;
        w_busy_n  = r_busy;
        w_err_n   = 1'b0;
        w_rd_i_n  = 1'b0;
        w_rd_d_n  = 1'b0;
        w_rxv_n   = 1'b0;
        w_nb      = '0;

        w_edge    = (r_div == DW'(TCK_DIV - 1));
        w_rise    = (r_state != ST_IDLE) && w_edge && !r_tck;
        w_fall    = (r_state != ST_IDLE) && w_edge && r_tck;
        w_dr_last = empty_data || (r_bytes == BW'(FIFO_DEPTH));

        // A TCK period begins in the clk after w_fall; tms/tdi for it are loaded there.
        if (r_state != ST_IDLE) begin
            if (w_edge) begin
                w_div_n = '0;
                w_tck_n = !r_tck;
            end else begin
                w_div_n = r_div + DW'(1);
            end
        end

        case (r_state)
            ST_TLR: begin
                if (w_fall) begin
                    if (r_cnt == CW'(5)) begin
                        w_state_n = ST_IDLE;
                        w_busy_n  = 1'b0;
                        w_tms_n   = 1'b0;
                        w_cnt_n   = '0;
                    end else begin
                        w_cnt_n = r_cnt + CW'(1);
                        w_tms_n = (r_cnt != CW'(4));
                    end
                end
            end
            ST_IDLE: begin
                if (work) begin
                    if (!op && !empty_instruction) begin
                        w_rd_i_n  = 1'b1;
                        w_tx_n    = W'(rdata_instruction);
                        w_op_n    = 1'b0;
                        w_busy_n  = 1'b1;
                        w_tms_n   = 1'b1;
                        w_cnt_n   = '0;
                        w_state_n = ST_IR_HDR;
                    end else if (op && !empty_data) begin
                        w_rd_d_n  = 1'b1;
                        w_tx_n    = W'(rdata_data);
                        w_bytes_n = BW'(1);
                        w_op_n    = 1'b1;
                        w_busy_n  = 1'b1;
                        w_tms_n   = 1'b1;
                        w_cnt_n   = '0;
                        w_state_n = ST_DR_HDR;
                    end else begin
                        w_err_n = 1'b1;
                    end
                end
            end
            ST_IR_HDR: begin
                if (w_fall) begin
                    if (r_cnt == CW'(3)) begin
                        w_state_n = ST_SHIFT;
                        w_tdi_n   = r_tx[0];
                        w_tx_n    = r_tx >> 1;
                        w_tms_n   = (DATA_INSTRUCTION == 1);
                        w_cnt_n   = '0;
                    end else begin
                        w_cnt_n = r_cnt + CW'(1);
                        w_tms_n = (r_cnt == CW'(0));
                    end
                end
            end
            ST_DR_HDR: begin
                if (w_fall) begin
                    if (r_cnt == CW'(2)) begin
                        w_state_n = ST_SHIFT;
                        w_tdi_n   = r_tx[0];
                        w_tx_n    = r_tx >> 1;
                        w_tms_n   = (DATA_FIFO == 1) && w_dr_last;
                        w_cnt_n   = '0;
                    end else begin
                        w_cnt_n = r_cnt + CW'(1);
                        w_tms_n = 1'b0;
                    end
                end
            end
            ST_SHIFT: begin
                if (w_rise && r_op) begin
                    w_rx_n = {tdo, r_rx[DATA_FIFO-1:1]};
                    if (r_cnt == CW'(DATA_FIFO - 1)) begin
                        w_rxd_n = {tdo, r_rx[DATA_FIFO-1:1]};
                        w_rxv_n = 1'b1;
                        // Next byte is latched now; its bit 0 goes out on the coming fall.
                        if (!r_tms) begin
                            w_rd_d_n  = 1'b1;
                            w_tx_n    = W'(rdata_data);
                            w_bytes_n = r_bytes + BW'(1);
                        end
                    end
                end
                if (w_fall) begin
                    if (r_tms) begin
                        w_state_n = ST_TAIL;
                        w_tms_n   = 1'b1;
                        w_tdi_n   = 1'b0;
                        w_cnt_n   = '0;
                    end else begin
                        if (r_op && r_cnt == CW'(DATA_FIFO - 1)) w_nb = '0;
                        else                                     w_nb = r_cnt + CW'(1);
                        w_cnt_n = w_nb;
                        w_tdi_n = r_tx[0];
                        w_tx_n  = r_tx >> 1;
                        w_tms_n = r_op ? ((w_nb == CW'(DATA_FIFO - 1)) && w_dr_last)
                                       : (w_nb == CW'(DATA_INSTRUCTION - 1));
                    end
                end
            end
            ST_TAIL: begin
                if (w_fall) begin
                    if (r_cnt == CW'(0)) begin
                        w_cnt_n = CW'(1);
                        w_tms_n = 1'b0;
                    end else begin
                        w_state_n = ST_IDLE;
                        w_busy_n  = 1'b0;
                        w_tms_n   = 1'b0;
                        w_cnt_n   = '0;
                    end
                end
            end
            default: w_state_n = ST_TLR;
        endcase
    end

    assign tck            = r_tck;
    assign tms            = r_tms;
    assign tdi            = r_tdi;
    assign busy           = r_busy;
    assign err_empty      = r_err;
    assign rd_instruction = r_rd_i;
    assign rd_data        = r_rd_d;
    assign rx_data        = r_rxd;
    assign rx_valid       = r_rxv;

endmodule

// File: tb/tb_jtag_tap_master.sv
// Bench for jtag_tap_master: FIFO models, TCK-level monitor and a scan-stream
// reference built from the TAP path rules (header, LSB-first bits, tail).
module tb_jtag_tap_master;
    localparam int DI  = 10;
    localparam int DF  = 8;
    localparam int DIV = 4;

    logic clk = 1'b0, rst = 1'b1, op = 1'b0, work = 1'b0, inv = 1'b0;
    logic tdo;
    logic busy, err_empty, rd_instruction, rd_data, tck, tms, tdi, rx_valid;
    logic [DF-1:0] rx_data;
    logic empty_instruction, empty_data;
    logic [DI-1:0] rdata_instruction;
    logic [DF-1:0] rdata_data;
    logic busy2, err2, rdi2, rdd2, tck2, tms2, tdi2, rxv2;
    logic [DF-1:0] rxd2;

    always #5 clk = ~clk;

    jtag_tap_master #(.DATA_INSTRUCTION(DI), .DATA_FIFO(DF), .FIFO_DEPTH(16), .TCK_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .op(op), .work(work), .busy(busy), .err_empty(err_empty),
        .rdata_instruction(rdata_instruction), .rd_instruction(rd_instruction),
        .empty_instruction(empty_instruction), .rdata_data(rdata_data), .rd_data(rd_data),
        .empty_data(empty_data), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo),
        .rx_data(rx_data), .rx_valid(rx_valid));

    jtag_tap_master #(.DATA_INSTRUCTION(DI), .DATA_FIFO(DF), .FIFO_DEPTH(16), .TCK_DIV(2)) dut2 (
        .clk(clk), .rst(rst), .op(op), .work(work), .busy(busy2), .err_empty(err2),
        .rdata_instruction(rdata_instruction), .rd_instruction(rdi2),
        .empty_instruction(empty_instruction), .rdata_data(rdata_data), .rd_data(rdd2),
        .empty_data(empty_data), .tck(tck2), .tms(tms2), .tdi(tdi2), .tdo(tdo),
        .rx_data(rxd2), .rx_valid(rxv2));

    // Show-ahead FIFO models: the initial block writes, the pop process reads.
    logic [DI-1:0] imem [1024];
    logic [DF-1:0] dmem [1024];
    int iwp = 0, irp = 0, dwp = 0, drp = 0;
    assign empty_instruction = (irp == iwp);
    assign rdata_instruction = imem[irp];
    assign empty_data        = (drp == dwp);
    assign rdata_data        = dmem[drp];
    assign tdo               = tdi ^ inv;

    always @(posedge clk) begin
        if (rd_instruction && irp != iwp) irp <= irp + 1;
        if (rd_data && drp != dwp)        drp <= drp + 1;
    end

    // Monitor: {tms,tdi} at every rising tck, strobe counts, captured bytes.
    logic [1:0]    tck_q [$];
    logic [DF-1:0] rx_q [$];
    int n_rd_i = 0, n_rd_d = 0, n_err = 0, n_rise2 = 0;
    logic ptck = 1'b0, ptck2 = 1'b0;

    always @(negedge clk) begin
        if (tck && !ptck) tck_q.push_back({tms, tdi});
        if (tck2 && !ptck2) n_rise2 <= n_rise2 + 1;
        ptck  <= tck;
        ptck2 <= tck2;
        if (rd_instruction) n_rd_i <= n_rd_i + 1;
        if (rd_data)        n_rd_d <= n_rd_d + 1;
        if (err_empty)      n_err  <= n_err + 1;
        if (rx_valid)       rx_q.push_back(rx_data);
    end

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Expected TAP stream: {care_tdi, tms, tdi} per TCK.
    task automatic chk_stream(input logic o, input logic [DI-1:0] iw,
                              input logic [DF-1:0] by [$], input int base);
        logic [2:0] ex [$];
        if (!o) begin
            ex = '{3'b010, 3'b010, 3'b000, 3'b000};
            for (int i = 0; i < DI; i++) ex.push_back({1'b1, i == DI - 1, iw[i]});
        end else begin
            ex = '{3'b010, 3'b000, 3'b000};
            for (int j = 0; j < by.size(); j++)
                for (int i = 0; i < DF; i++)
                    ex.push_back({1'b1, (j == by.size() - 1) && (i == DF - 1), by[j][i]});
        end
        ex.push_back(3'b010);
        ex.push_back(3'b000);
        chk("stream_len", tck_q.size() - base, ex.size());
        for (int i = 0; i < ex.size() && base + i < tck_q.size(); i++) begin
            chk($sformatf("tms[%0d]", i), int'(tck_q[base + i][1]), int'(ex[i][1]));
            if (ex[i][2]) chk($sformatf("tdi[%0d]", i), int'(tck_q[base + i][0]), int'(ex[i][0]));
        end
    endtask

    task automatic chk_rx(input logic o, input logic [DF-1:0] by [$], input int rbase);
        int exp_n;
        exp_n = o ? by.size() : 0;
        chk("rx_count", rx_q.size() - rbase, exp_n);
        for (int j = 0; j < exp_n && rbase + j < rx_q.size(); j++)
            chk($sformatf("rx_data[%0d]", j), int'(rx_q[rbase + j]), int'(by[j] ^ {DF{inv}}));
    endtask

    task automatic run_scan(input logic o, output int bclks);
        op   = o;
        work = 1'b1;
        @(negedge clk);
        work  = 1'b0;
        bclks = 0;
        for (int k = 0; k < 4000 && busy; k++) begin
            bclks++;
            @(negedge clk);
        end
        chk("scan_done", int'(busy), 0);
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        logic          op;
        int            cnt;
        logic [DI-1:0] word;
        logic          inv;
        int            exp_tcks;
        int            exp_rd;
        int            exp_rxv;
        int            exp_err;
    } vec_t;

    vec_t tbl [6];
    logic [DF-1:0] by [$];
    int b_t, b_rx, b_ri, b_rd, b_e, bc, n, n2, nb, ip0;
    logic o;
    logic [DI-1:0] w;

    initial begin
        tbl[0] = '{1'b0, 1, 10'h220, 1'b0, 16, 1, 0, 0};
        tbl[1] = '{1'b1, 3, 10'h0C4, 1'b0, 29, 3, 3, 0};
        tbl[2] = '{1'b1, 0, 10'h000, 1'b0, 0, 0, 0, 1};
        tbl[3] = '{1'b0, 0, 10'h000, 1'b0, 0, 0, 0, 1};
        tbl[4] = '{1'b1, 1, 10'h05A, 1'b1, 13, 1, 1, 0};
        tbl[5] = '{1'b0, 1, 10'h3FF, 1'b0, 16, 1, 0, 0};

        // Reset values, then the TLR walk on both divider settings.
        repeat (3) @(negedge clk);
        chk("rst_tck", int'(tck), 0);
        chk("rst_tms", int'(tms), 1);
        chk("rst_tdi", int'(tdi), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_rd", int'({rd_instruction, rd_data, err_empty, rx_valid}), 0);
        chk("rst_rx_data", int'(rx_data), 0);
        rst = 1'b0;
        n = 0; n2 = 0;
        for (int k = 0; k < 200 && (busy || busy2); k++) begin
            if (busy)  n++;
            if (busy2) n2++;
            if (k == 20) begin op = 1'b0; work = 1'b1; end
            else work = 1'b0;
            @(negedge clk);
        end
        work = 1'b0;
        chk("tlr_busy_clks", n, 6 * 2 * DIV);
        chk("tlr_busy_clks_div2", n2, 24);
        chk("tlr_rises_div2", n_rise2, 6);
        chk("tlr_rises", tck_q.size(), 6);
        for (int i = 0; i < 6 && i < tck_q.size(); i++)
            chk($sformatf("tlr_tms[%0d]", i), int'(tck_q[i][1]), (i < 5) ? 1 : 0);
        chk("tlr_work_ignored", n_err + n_rd_i, 0);

        // Table-driven scans.
        for (int t = 0; t < 6; t++) begin
            by.delete();
            if (!tbl[t].op) begin
                for (int c = 0; c < tbl[t].cnt; c++) begin imem[iwp] = tbl[t].word; iwp++; end
            end else begin
                for (int c = 0; c < tbl[t].cnt; c++) begin
                    dmem[dwp] = tbl[t].word[DF-1:0]; dwp++;
                    by.push_back(tbl[t].word[DF-1:0]);
                end
            end
            inv = tbl[t].inv;
            repeat (2) @(negedge clk);
            b_t = tck_q.size(); b_rx = rx_q.size(); b_ri = n_rd_i; b_rd = n_rd_d; b_e = n_err;
            run_scan(tbl[t].op, bc);
            chk($sformatf("v%0d_tcks", t), tck_q.size() - b_t, tbl[t].exp_tcks);
            chk($sformatf("v%0d_rd", t), tbl[t].op ? n_rd_d - b_rd : n_rd_i - b_ri, tbl[t].exp_rd);
            chk($sformatf("v%0d_rxv", t), rx_q.size() - b_rx, tbl[t].exp_rxv);
            chk($sformatf("v%0d_err", t), n_err - b_e, tbl[t].exp_err);
            chk($sformatf("v%0d_busy_clks", t), bc, tbl[t].exp_tcks * 2 * DIV);
            if (tbl[t].exp_tcks > 0) chk_stream(tbl[t].op, tbl[t].word, by, b_t);
            chk_rx(tbl[t].op, by, b_rx);
        end

        // Randomized scans against the stream model.
        for (int r = 0; r < 12; r++) begin
            by.delete();
            o   = 1'($urandom_range(0, 1));
            inv = 1'($urandom_range(0, 1));
            w   = DI'($urandom);
            if (!o) begin
                imem[iwp] = w; iwp++;
            end else begin
                nb = $urandom_range(1, 4);
                for (int c = 0; c < nb; c++) begin
                    by.push_back(DF'($urandom));
                    dmem[dwp] = by[c]; dwp++;
                end
            end
            repeat (2) @(negedge clk);
            b_t = tck_q.size(); b_rx = rx_q.size(); b_ri = n_rd_i; b_rd = n_rd_d;
            run_scan(o, bc);
            chk($sformatf("r%0d_rd", r), o ? n_rd_d - b_rd : n_rd_i - b_ri, o ? by.size() : 1);
            chk_stream(o, w, by, b_t);
            chk_rx(o, by, b_rx);
        end

        // work pulse in the middle of a DR scan is ignored.
        by.delete();
        by.push_back(8'h3C); by.push_back(8'hA5);
        dmem[dwp] = 8'h3C; dwp++;
        dmem[dwp] = 8'hA5; dwp++;
        imem[iwp] = 10'h155; iwp++;
        inv = 1'b0;
        repeat (2) @(negedge clk);
        b_t = tck_q.size(); b_rx = rx_q.size(); b_ri = n_rd_i; b_rd = n_rd_d; b_e = n_err;
        op = 1'b1; work = 1'b1;
        @(negedge clk);
        work = 1'b0;
        repeat (60) @(negedge clk);
        op = 1'b0; work = 1'b1;
        @(negedge clk);
        work = 1'b0;
        for (int k = 0; k < 4000 && busy; k++) @(negedge clk);
        chk("mid_done", int'(busy), 0);
        repeat (4) @(negedge clk);
        chk("mid_tcks", tck_q.size() - b_t, 21);
        chk("mid_rd_data", n_rd_d - b_rd, 2);
        chk("mid_rd_instr", n_rd_i - b_ri, 0);
        chk("mid_err", n_err - b_e, 0);
        chk("mid_ififo_level", iwp - irp, 1);
        chk_stream(1'b1, '0, by, b_t);
        chk_rx(1'b1, by, b_rx);

        // Reset during IR bit 5, work during the TLR walk, then a clean IR scan.
        imem[iwp] = 10'h2A3; iwp++;
        repeat (2) @(negedge clk);
        b_t = tck_q.size();
        op = 1'b0; work = 1'b1;
        @(negedge clk);
        work = 1'b0;
        for (int k = 0; k < 2000 && (tck_q.size() - b_t) < 9; k++) @(negedge clk);
        chk("rst_point_reached", tck_q.size() - b_t, 9);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_tck", int'(tck), 0);
        chk("mrst_tms", int'(tms), 1);
        chk("mrst_busy", int'(busy), 1);
        chk("mrst_strobes", int'({rd_instruction, rd_data, rx_valid, err_empty}), 0);
        rst = 1'b0;
        b_t = tck_q.size(); ip0 = irp; b_e = n_err;
        n = 0;
        for (int k = 0; k < 200 && busy; k++) begin
            n++;
            if (k == 10) begin op = 1'b0; work = 1'b1; end
            else work = 1'b0;
            @(negedge clk);
        end
        work = 1'b0;
        chk("mrst_tlr_clks", n, 6 * 2 * DIV);
        chk("mrst_tlr_rises", tck_q.size() - b_t, 6);
        for (int i = 0; i < 6 && b_t + i < tck_q.size(); i++)
            chk($sformatf("mrst_tms[%0d]", i), int'(tck_q[b_t + i][1]), (i < 5) ? 1 : 0);
        chk("mrst_work_ignored", irp - ip0 + n_err - b_e, 0);
        by.delete();
        repeat (2) @(negedge clk);
        b_t = tck_q.size(); b_ri = n_rd_i; b_rx = rx_q.size();
        run_scan(1'b0, bc);
        chk("post_rst_rd", n_rd_i - b_ri, 1);
        chk("post_rst_busy_clks", bc, 16 * 2 * DIV);
        chk_stream(1'b0, 10'h2A3, by, b_t);
        chk_rx(1'b0, by, b_rx);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/jtag_tap_master.md
Name: jtag_tap_master

Overview:
- Consumer end of the instruction and data FIFOs filled by the JTAG command sequencer.
- On a `work` pulse it pops the instruction FIFO (IR scan, op=0) or the data FIFO (DR scan, op=1) and drives the TAP pins `tck`/`tms`/`tdi`.
- It captures `tdo` into bytes and reports progress on `busy`.
- After reset it puts the target TAP into Run-Test/Idle (RTI) before accepting any command.

Parameters:
- DATA_INSTRUCTION, 10, IR length in bits; also the instruction FIFO word width.
- DATA_FIFO, 8, data FIFO word width in bits.
- FIFO_DEPTH, 16, FIFO depth; sets the usedw width.
- TCK_DIV, 4, clk cycles per TCK half-period; legal range is >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- op  in  1  0 = IR scan, 1 = DR scan; sampled together with `work`
- work  in  1  start pulse, one clk wide
- busy  out  1  high while a TAP sequence is in progress
- err_empty  out  1  one-clk pulse when the source FIFO is empty at start
- rdata_instruction  in  DATA_INSTRUCTION  show-ahead FIFO head word
- rd_instruction  out  1  pop strobe, one clk
- empty_instruction  in  1  instruction FIFO empty
- rdata_data  in  DATA_FIFO  show-ahead FIFO head word
- rd_data  out  1  pop strobe, one clk
- empty_data  in  1  data FIFO empty
- tck  out  1  JTAG clock; idles low
- tms  out  1  JTAG mode select
- tdi  out  1  JTAG data out
- tdo  in  1  JTAG data in; already synchronised externally
- rx_data  out  DATA_FIFO  captured byte
- rx_valid  out  1  one-clk strobe when rx_data is valid

Behaviour:
- Clocking and reset
  - Clock is clk. Reset is rst: synchronous, active-high.
  - Reset values: tck=0, tms=1, tdi=0, busy=1, rd_*=0, err_empty=0, rx_valid=0, rx_data=0. Divider, counters and shift registers are cleared.
- TCK generation
  - Each TCK period is a low phase of TCK_DIV clk cycles followed by a high phase of TCK_DIV cycles.
  - tms/tdi update in the first clk of the low phase.
  - tdo is sampled in the clk where tck goes 0->1.
  - All outputs are registered.
- State machine:
  - ST_TLR: 5 TCKs with tms=1, then 1 TCK with tms=0 -> ST_IDLE.
  - ST_IDLE: tck=0, tms=0, busy=0.
    - On work=1, op=0, !empty_instruction: pulse rd_instruction for one clk, latch rdata_instruction, busy=1 -> ST_IR_HDR.
    - On work=1, op=1, !empty_data: pulse rd_data, latch the byte, busy=1 -> ST_DR_HDR.
    - On work with the selected FIFO empty: err_empty pulses for one clk, no TCK, stay in ST_IDLE.
  - ST_IR_HDR: tms sequence 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR) -> ST_SHIFT.
  - ST_DR_HDR: tms sequence 1,0,0 (Select-DR, Capture-DR, Shift-DR) -> ST_SHIFT.
  - ST_SHIFT: one bit per TCK, LSB first, on tdi.
    - IR: DATA_INSTRUCTION bits; tms=1 on the last bit.
    - DR, at bit DATA_FIFO-1 of each byte:
      - if empty_data=1 (evaluated after the prior pop): tms=1, this is the last bit;
      - else: tms=0, pulse rd_data in the clk after that TCK's rising edge, and load the next byte.
    - -> ST_TAIL.
  - ST_TAIL: tms 1 (Update), then 0 (RTI) -> ST_IDLE. busy falls in the clk after the final falling edge.
- Capture
  - Sampled tdo bits shift in LSB first during DR shift bits only; no capture occurs during IR scans.
  - After DATA_FIFO bits: rx_data is updated and rx_valid pulses for one clk.
- TCK counts
  - IR scan = 4 + DATA_INSTRUCTION + 2 TCKs.
  - DR scan = 3 + 8·N + 2 TCKs for N bytes.
- Boundary conditions
  - work while busy=1 is ignored; no pop, no error pulse.
  - work during ST_TLR is ignored.
  - Data FIFO must be fully loaded before work. Bytes written after the emptiness check of the last byte belong to the next scan.
  - rst mid-scan: outputs return to reset values within one clk, then the ST_TLR sequence repeats. FIFO words already popped are lost.
  - TCK_DIV=2 must produce exactly 4 clk per TCK period.

Test Plan:
- Reset release, TCK_DIV=4 -> busy=1, 5 rising tck edges with tms=1, 1 with tms=0, then busy=0; 48 clk with tck toggling.
- IR scan, instruction FIFO holds 10'b1000100000, work op=0 ->
  - rd_instruction pulses once;
  - 16 TCKs: tms=1,1,0,0, then tdi=0,0,0,0,0,1,0,0,0,1 with tms=1 only on the 10th bit, then tms=1,0;
  - busy falls; rx_valid never pulses.
- DR scan, 3 bytes 0xC4, tdo looped to tdi, work op=1 ->
  - 29 TCKs; rd_data pulses 3 times;
  - rx_valid pulses 3 times with rx_data=0xC4; tms=1 only on bit 24 and the first tail TCK.
- work op=1 with empty_data=1 -> err_empty pulses 1 clk, tck stays 0, busy stays 0.
- work pulse mid-DR-scan -> ignored: rd counts and TCK count unchanged.
- rst asserted at IR bit 5 -> next clk: tck=0, tms=1, busy=1; then the full 6-TCK TLR sequence; a later IR scan completes normally.
